// File: rtl/mem_model_pipelined.sv
// mem_model_pipelined: parametrised single-port simulation memory with byte-lane writes, a READ_LATENCY-deep read pipeline and an out-of-range flag.
// Define MEM_FWD_EN to forward same-cycle write data into the read (write-first); otherwise reads are read-first.
module mem_model_pipelined #(
  parameter int DATA_WIDTH   = 16,
  parameter int MEM_DEPTH    = 4096,
  parameter int ADDR_WIDTH   = $clog2(MEM_DEPTH),
  parameter int READ_LATENCY = 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    en,
  input  logic                    rd_en,
  input  logic                    wr_en,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic [DATA_WIDTH-1:0]   din,
  input  logic [DATA_WIDTH/8-1:0] byte_en,
  output logic [DATA_WIDTH-1:0]   dout,
  output logic                    dout_valid,
  output logic                    addr_err
);
  localparam int NB = DATA_WIDTH / 8;
  localparam int L  = READ_LATENCY;
  logic [DATA_WIDTH-1:0] ram [0:MEM_DEPTH-1];
  logic                  oor, rd_acc, wr_acc;
  logic [DATA_WIDTH-1:0] word, rd_data;
  logic [L-1:0]          sv, se, vin, ein;
  logic [DATA_WIDTH-1:0] sd [L];
  logic [DATA_WIDTH-1:0] dn [L];
  assign oor    = {1'b0, addr} >= (ADDR_WIDTH+1)'(MEM_DEPTH);
  assign rd_acc = en && rd_en;
  assign wr_acc = en && wr_en && !oor;
  assign word   = oor ? '0 : ram[addr];
`ifdef MEM_FWD_EN
  always_comb begin
    rd_data = word;
    for (int i = 0; i < NB; i++)
      if (wr_acc && byte_en[i]) rd_data[8*i +: 8] = din[8*i +: 8];
  end
`else
  assign rd_data = word;
`endif
  // Stage inputs: stage 0 takes the new request, stage i takes stage i-1.
  always_comb begin
    vin    = '0;
    ein    = '0;
    vin[0] = rd_acc;
    ein[0] = en && (rd_en || wr_en) && oor;
    dn[0]  = rd_data;
    for (int i = 1; i < L; i++) begin
      vin[i] = sv[i-1];
      ein[i] = se[i-1];
      dn[i]  = sd[i-1];
    end
  end
  // The last stage is the output register and only loads when a read completes.
  always_ff @(posedge clock) begin
    if (!reset) begin
      sv       <= '0;
      se       <= '0;
      sd[L-1]  <= '0;
    end else begin
      sv <= vin;
      se <= ein;
      for (int i = 0; i < L; i++)
        if (i < L-1 || vin[i]) sd[i] <= dn[i];
    end
  end
  always_ff @(posedge clock)
    if (reset && wr_acc)
      for (int i = 0; i < NB; i++)
        if (byte_en[i]) ram[addr][8*i +: 8] <= din[8*i +: 8];
  assign dout       = sd[L-1];
  assign dout_valid = sv[L-1];
  assign addr_err   = se[L-1];
endmodule

// File: tb/tb_mem_model_pipelined.sv
// tb_mem_model_pipelined: directed plus random stimulus against a queue-based reference of the memory, depth 3000, latency 3.
module tb_mem_model_pipelined;
  localparam int DEPTH = 3000;
  localparam int L     = 3;
  typedef struct {
    int          due;
    logic        v;
    logic        e;
    logic [15:0] d;
  } ent_t;
  logic        clock = 0;
  logic        reset, en, rd_en, wr_en;
  logic [11:0] addr;
  logic [15:0] din;
  logic [1:0]  byte_en;
  logic [15:0] dout;
  logic        dout_valid, addr_err;
  logic [15:0] mem [DEPTH];
  ent_t        q[$];
  logic [15:0] exp_dout;
  logic        exp_v, exp_e;
  int          cyc, checks, errors;

  mem_model_pipelined #(.DATA_WIDTH(16), .MEM_DEPTH(DEPTH), .READ_LATENCY(L)) dut (
    .clock(clock), .reset(reset), .en(en), .rd_en(rd_en), .wr_en(wr_en), .addr(addr),
    .din(din), .byte_en(byte_en), .dout(dout), .dout_valid(dout_valid), .addr_err(addr_err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle %0d observed %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  // Applies one cycle of inputs, advances the reference at the edge, then compares.
  task automatic step(input logic r, input logic e, input logic rd, input logic wr,
                      input logic [11:0] a, input logic [15:0] d, input logic [1:0] be);
    ent_t n;
    logic o;
    reset = r; en = e; rd_en = rd; wr_en = wr; addr = a; din = d; byte_en = be;
    @(posedge clock);
    cyc++;
    if (!r) begin
      q.delete();
      exp_dout = '0;
      exp_v    = 0;
      exp_e    = 0;
    end else begin
      o = int'(a) >= DEPTH;
      if (e && (rd || (wr && o))) begin
        n.due = cyc + L - 1;
        n.v   = rd;
        n.e   = o;
        n.d   = o ? 16'h0 : mem[a];
`ifdef MEM_FWD_EN
        if (wr && !o)
          for (int i = 0; i < 2; i++) if (be[i]) n.d[8*i +: 8] = d[8*i +: 8];
`endif
        q.push_back(n);
      end
      if (e && wr && !o)
        for (int i = 0; i < 2; i++) if (be[i]) mem[a][8*i +: 8] = d[8*i +: 8];
      exp_v = 0;
      exp_e = 0;
      if (q.size() > 0 && q[0].due == cyc) begin
        n     = q.pop_front();
        exp_v = n.v;
        exp_e = n.e;
        if (n.v) exp_dout = n.d;
      end
    end
    #1;
    chk("dout", dout, exp_dout);
    chk("dout_valid", 16'(dout_valid), 16'(exp_v));
    chk("addr_err", 16'(addr_err), 16'(exp_e));
  endtask

  task automatic idle();
    step(1, 0, 0, 0, 12'd0, 16'h0, 2'b00);
  endtask

  initial begin
    logic [15:0] v;
    cyc = 0; checks = 0; errors = 0;
    exp_dout = '0; exp_v = 0; exp_e = 0;
    reset = 0; en = 0; rd_en = 0; wr_en = 0; addr = '0; din = '0; byte_en = '0;
    step(0, 0, 0, 0, 12'd0, 16'h0, 2'b00);
    step(0, 1, 1, 0, 12'd0, 16'h0, 2'b00);
    for (int a = 0; a < DEPTH; a++) begin
      v = (a == 0) ? 16'h1234 : (a == 1) ? 16'hABCD : (a == 7) ? 16'h1111 : 16'($urandom);
      step(1, 1, 0, 1, 12'(a), v, 2'b11);
    end
    step(0, 1, 0, 1, 12'd0, 16'hDEAD, 2'b11);
    step(0, 0, 0, 0, 12'd0, 16'h0, 2'b00);
    step(1, 1, 1, 0, 12'd0, 16'h0, 2'b00);
    step(1, 1, 1, 0, 12'd1, 16'h0, 2'b00);
    idle();
    chk("preload0", dout, 16'h1234);
    idle();
    chk("preload1", dout, 16'hABCD);
    step(1, 1, 0, 1, 12'd5, 16'hFFFF, 2'b11);
    step(1, 1, 0, 1, 12'd5, 16'h0000, 2'b01);
    step(1, 1, 1, 0, 12'd5, 16'h0, 2'b00);
    idle();
    idle();
    chk("bytemask", dout, 16'hFF00);
    for (int a = 0; a < 4; a++) step(1, 1, 1, 0, 12'(a), 16'h0, 2'b00);
    for (int k = 0; k < L; k++) idle();
    step(1, 1, 1, 1, 12'd7, 16'h2222, 2'b11);
    idle();
    idle();
`ifdef MEM_FWD_EN
    chk("collide", dout, 16'h2222);
`else
    chk("collide", dout, 16'h1111);
`endif
    step(1, 1, 1, 0, 12'd7, 16'h0, 2'b00);
    idle();
    idle();
    chk("after_collide", dout, 16'h2222);
    step(1, 1, 0, 1, 12'd3500, 16'hBEEF, 2'b11);
    idle();
    idle();
    chk("oor_wr_err", 16'(addr_err), 16'd1);
    step(1, 1, 1, 0, 12'd3500, 16'h0, 2'b00);
    idle();
    idle();
    chk("oor_rd_data", dout, 16'h0);
    chk("oor_rd_err", 16'(addr_err), 16'd1);
    step(1, 1, 1, 0, 12'd3, 16'h0, 2'b00);
    idle();
    step(0, 0, 0, 0, 12'd0, 16'h0, 2'b00);
    chk("midreset_dout", dout, 16'h0);
    for (int k = 0; k < L + 2; k++) idle();
    chk("midreset_valid", 16'(dout_valid), 16'd0);
    for (int k = 0; k < 600; k++)
      step(($urandom_range(0, 39) != 0), ($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom),
           12'($urandom_range(0, 3199)), 16'($urandom), 2'($urandom));
    for (int k = 0; k < L + 1; k++) idle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_model_pipelined.md
Name: mem_model_pipelined

Overview:
- Parametrised successor of the 16-bit single-port simulation memory that the CPU memory controller drives.
- Generalises data width, depth and read latency, and adds:
  - byte-lane write masking
  - a read-valid strobe
  - an out-of-range error flag
- Sits behind MEMCTRL in top-level benches.
- Preloaded by hierarchical $fread into array `ram` while reset is asserted.

Parameters:
- DATA_WIDTH, 16, word width in bits; must be a multiple of 8.
- MEM_DEPTH, 4096, number of words; need not be a power of 2.
- ADDR_WIDTH, $clog2(MEM_DEPTH), address width (derived; do not override).
- READ_LATENCY, 1, cycles from accepted read to dout_valid; legal range 1..8.

Ports:
- clock, input, 1, single clock; all logic on the rising edge.
- reset, input, 1, synchronous active-low reset.
- en, input, 1, memory enable; rd_en and wr_en are ignored when low.
- rd_en, input, 1, read request.
- wr_en, input, 1, write request.
- addr, input, ADDR_WIDTH, word address.
- din, input, DATA_WIDTH, write data.
- byte_en, input, DATA_WIDTH/8, write lane mask; bit i covers din[8i+7:8i].
- dout, output, DATA_WIDTH, read data.
- dout_valid, output, 1, one-cycle strobe marking dout as the result of a read.
- addr_err, output, 1, one-cycle strobe: the access accepted READ_LATENCY cycles earlier was out of range.

Behaviour:
- Storage: array `ram[0:MEM_DEPTH-1]` of DATA_WIDTH bits.
  - Contents are never cleared by reset, so a file preload during reset survives.
- Reset (reset==0 at a rising edge):
  - dout=0, dout_valid=0, addr_err=0.
  - All read-pipeline stages invalidated.
  - Requests presented in a reset cycle are dropped, including any write.
  - Reset asserted mid-read: the pending result is discarded and no dout_valid appears after reset releases.
- Write acceptance: en&wr_en, reset high, addr<MEM_DEPTH.
  - Lanes with byte_en[i]=1 are updated at that edge; other lanes keep old data.
  - byte_en all zero: no change.
- Read acceptance: en&rd_en, reset high.
  - Stage 1 captures ram[addr] (read-first) and a valid bit.
  - READ_LATENCY-1 further register stages follow.
  - dout and dout_valid update together exactly READ_LATENCY edges after the accepting edge.
  - dout holds its last value while no read completes; dout_valid is high for one cycle per read.
- Back-to-back reads on consecutive cycles are fully pipelined: one result per cycle, in order.
- Simultaneous rd_en&wr_en to the same address: the write commits, and the read returns pre-write data unless MEM_FWD_EN is defined.
  - Different addresses: both performed independently.
- Out of range (addr>=MEM_DEPTH, reachable only when MEM_DEPTH is not a power of 2):
  - Writes are ignored.
  - Reads return 0 with dout_valid=1.
  - addr_err pulses aligned with the dout_valid slot.
  - A write-only error pulses addr_err READ_LATENCY cycles later, with dout_valid=0.
- en=0: no access, no error, pipeline keeps draining.
- In-flight reads are unaffected by later writes: data was sampled at acceptance.

Optional Feature:
- Macro: MEM_FWD_EN.
- Defined: on a same-cycle read and write to the same in-range address, stage 1 captures the merged value.
  - Enabled lanes come from din; other lanes come from ram (write-first).
  - Later reads always see committed data.
- Undefined: read-first as above; no forwarding mux is synthesised.

Test Plan:
- Preload and read back:
  - Stimulus: DATA_WIDTH=16, READ_LATENCY=1; hold reset low 2 cycles while loading ram[0]=16'h1234, ram[1]=16'hABCD; release reset; read addr 0 then addr 1 on consecutive cycles.
  - Response: dout=1234 then ABCD on consecutive cycles, each with dout_valid=1.
  - Also: contents are intact after reset.
- Byte mask:
  - Stimulus: write addr 5 din=16'hFFFF byte_en=2'b11; then din=16'h0000 byte_en=2'b01; then read addr 5.
  - Response: dout=16'hFF00.
- Latency and pipelining:
  - Stimulus: READ_LATENCY=3; reads to addr 0..3 on 4 consecutive cycles.
  - Response: dout_valid high on cycles 3..6 after the first request, with data in address order; no valid before cycle 3.
- Collision:
  - Stimulus: ram[7]=16'h1111; same-cycle read and write to addr 7 with din=16'h2222, byte_en=2'b11.
  - Response: without MEM_FWD_EN dout=1111; with MEM_FWD_EN dout=2222; a subsequent read returns 2222 in both builds.
- Out of range:
  - Stimulus: MEM_DEPTH=3000; write addr 3500 din=16'hBEEF, then read addr 3500.
  - Response: addr_err pulses for each access; the read returns dout=0 with dout_valid=1; ram is unchanged (ram[3500 mod 4096] is never written).
- Reset mid-read:
  - Stimulus: READ_LATENCY=4; issue a read, then assert reset for 1 cycle 2 cycles later.
  - Response: dout=0, dout_valid stays low for the remainder, and no stale strobe follows reset release.
